// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file for the npc core.
// Holds the M-mode trap CSRs and the 64-bit cycle/instret counters.
// Trap entry, mret and timer-interrupt entry all end in a registered
// PC redirect that is held until fetch accepts it.
module csr_unit #(
  parameter int          XLEN         = 32,
  parameter logic [63:0] MTVEC_RESET  = 64'd0,
  parameter int          HAS_COUNTERS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        csr_op_i,
  input  logic [11:0]       csr_addr_i,
  input  logic [XLEN-1:0]   csr_wdata_i,
  output logic [XLEN-1:0]   csr_rdata_o,
  output logic              csr_illegal_o,
  input  logic              trap_valid_i,
  input  logic [XLEN-1:0]   trap_cause_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  logic              mret_i,
  input  logic              irq_timer_i,
  input  logic [XLEN-1:0]   int_pc_i,
  input  logic              retire_i,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  input  logic              redirect_ready_i
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef enum logic {S_IDLE, S_REDIRECT} state_t;

  state_t            state_q;
  logic              redirect_valid_q;
  logic [XLEN-1:0]   redirect_pc_q;

  logic              mie_q, mpie_q, mtie_q;
  logic [XLEN-1:0]   mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0]       mcycle_q, minstret_q;
  logic [63:0]       mcycle_d, minstret_d;

  logic [XLEN-1:0]   rd_val;
  logic              addr_impl, addr_ro;
  logic              wr_req, illegal, csr_we;
  logic [XLEN-1:0]   csr_new;

  logic              in_idle, irq_pend;
  logic              take_trap, take_mret, take_irq, event_take;
  logic [XLEN-1:0]   mtvec_base, evt_target;

  // Address decode: raw read value plus implemented / read-only flags
  always_comb begin
    rd_val    = '0;
    addr_impl = 1'b1;
    addr_ro   = 1'b0;
    case (csr_addr_i)
      12'h300: begin
        rd_val[12:11] = 2'b11;
        rd_val[7]     = mpie_q;
        rd_val[3]     = mie_q;
      end
      12'h304: rd_val[7] = mtie_q;
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h344: begin
        rd_val[7] = irq_timer_i;
        addr_ro   = 1'b1;
      end
      12'hB00: if (HAS_COUNTERS != 0) rd_val = mcycle_q[XLEN-1:0];
      12'hB02: if (HAS_COUNTERS != 0) rd_val = minstret_q[XLEN-1:0];
      12'hB80: begin
        if (XLEN != 32) addr_impl = 1'b0;
        else if (HAS_COUNTERS != 0) rd_val = XLEN'(mcycle_q[63:32]);
      end
      12'hB82: begin
        if (XLEN != 32) addr_impl = 1'b0;
        else if (HAS_COUNTERS != 0) rd_val = XLEN'(minstret_q[63:32]);
      end
      12'hF14: addr_ro = 1'b1;
      default: addr_impl = 1'b0;
    endcase
  end

  // Read-modify-write value and legality; set/clear with zero is a pure read
  always_comb begin
    wr_req  = (csr_op_i == OP_RW) ||
              (((csr_op_i == OP_RS) || (csr_op_i == OP_RC)) && (csr_wdata_i != '0));
    illegal = (csr_op_i != OP_NONE) && (!addr_impl || (addr_ro && wr_req));
    case (csr_op_i)
      OP_RW:   csr_new = csr_wdata_i;
      OP_RS:   csr_new = rd_val | csr_wdata_i;
      OP_RC:   csr_new = rd_val & ~csr_wdata_i;
      default: csr_new = rd_val;
    endcase
    // an event taken this cycle swallows the CSR op
    csr_we  = wr_req && !illegal && !event_take;
  end

  assign csr_rdata_o   = illegal ? '0 : rd_val;
  assign csr_illegal_o = illegal;

  // Event arbitration: trap > mret > interrupt, only while idle
  always_comb begin
    in_idle    = (state_q == S_IDLE);
    irq_pend   = mie_q && mtie_q && irq_timer_i;
    take_trap  = in_idle && trap_valid_i;
    take_mret  = in_idle && !trap_valid_i && mret_i;
    take_irq   = in_idle && !trap_valid_i && !mret_i && irq_pend;
    event_take = take_trap || take_mret || take_irq;
    mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    if (take_trap)                   evt_target = mtvec_base;
    else if (take_mret)              evt_target = mepc_q;
    else if (mtvec_q[1:0] == 2'b01)  evt_target = mtvec_base + XLEN'(28);
    else                             evt_target = mtvec_base;
  end

  // Redirect FSM: capture target on an event, hold until fetch accepts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (event_take) begin
            state_q          <= S_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= evt_target;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready_i) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= S_IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

  // mstatus interrupt-enable stacking and mie.MTIE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
      mtie_q <= 1'b0;
    end else begin
      if (take_trap || take_irq) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
      end else if (take_mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (csr_we && csr_addr_i == 12'h300) begin
        mie_q  <= csr_new[3];
        mpie_q <= csr_new[7];
      end
      if (csr_we && csr_addr_i == 12'h304) mtie_q <= csr_new[7];
    end
  end

  // mtvec (MODE 2/3 collapse to direct), mscratch, mepc, mcause
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtvec_q    <= MTVEC_RESET[XLEN-1:0];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      if (csr_we && csr_addr_i == 12'h305)
        mtvec_q <= {csr_new[XLEN-1:2], 1'b0, ~csr_new[1] & csr_new[0]};
      if (csr_we && csr_addr_i == 12'h340)
        mscratch_q <= csr_new;
      if (take_trap) begin
        mepc_q   <= trap_pc_i & ~XLEN'(3);
        mcause_q <= trap_cause_i;
      end else if (take_irq) begin
        mepc_q   <= int_pc_i & ~XLEN'(3);
        mcause_q <= {1'b1, (XLEN-1)'(7)};
      end else begin
        if (csr_we && csr_addr_i == 12'h341) mepc_q   <= csr_new & ~XLEN'(3);
        if (csr_we && csr_addr_i == 12'h342) mcause_q <= csr_new;
      end
    end
  end

  // Counter next state: a written half takes the write, the other keeps counting
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = retire_i ? (minstret_q + 64'd1) : minstret_q;
    if (csr_we && csr_addr_i == 12'hB00) mcycle_d[XLEN-1:0]   = csr_new;
    if (csr_we && csr_addr_i == 12'hB02) minstret_d[XLEN-1:0] = csr_new;
    if (XLEN == 32) begin
      if (csr_we && csr_addr_i == 12'hB80) mcycle_d[63:32]   = csr_new[31:0];
      if (csr_we && csr_addr_i == 12'hB82) minstret_d[63:32] = csr_new[31:0];
    end
  end

  // Counter registers; tied to zero when counters are not built
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= (HAS_COUNTERS != 0) ? mcycle_d   : 64'd0;
      minstret_q <= (HAS_COUNTERS != 0) ? minstret_d : 64'd0;
    end
  end

endmodule
